board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system/pixel clock; all state on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port h_cnt, input, 11 bits: horizontal pixel counter from VGA timing; 0..639 is active.
REQ-004 SHALL have port v_cnt, input, 11 bits: vertical line counter; 0..479 is active, 480 and above is vertical blanking.
REQ-005 SHALL have port board_in, input, 64 bits: 16 cells of 4-bit tile codes; cell k (k=0..15, row-major) occupies bits [4k+3:4k].
REQ-006 SHALL have port board_valid, input, 1 bit: board_in holds a new board; held high until board_ack.
REQ-007 SHALL have port board_ack, output, 1 bit: one-cycle pulse when board_in is latched.
REQ-008 SHALL have port curpos, output, 5 bits: tile index 1..16 under the pixel, 0 outside all tiles.
REQ-009 SHALL have port curdata, output, 4 bits: tile code of curpos; 0 when curpos=0.
REQ-010 SHALL have port h_cnt_d, output, 11 bits: h_cnt delayed to align with curpos/curdata.
REQ-011 SHALL have port v_cnt_d, output, 11 bits: v_cnt delayed to align with curpos/curdata.

Function
REQ-012 SHALL place tile columns at x = 136..215, 232..311, 328..407, 424..503 (80 px wide, pitch 96).
REQ-013 SHALL place tile rows at y = 66..145, 162..241, 258..337, 354..433.
REQ-014 SHALL set curpos = row*4 + col + 1 (row, col 0..3) inside a tile; gap pixels, border pixels and blanking pixels SHALL give 0.
REQ-015 SHALL source curdata from the shadow board cell curpos-1, never directly from board_in.
REQ-016 SHALL register curpos, curdata, h_cnt_d and v_cnt_d with exactly 1 clk latency from h_cnt/v_cnt.
REQ-017 SHALL use a two-state handshake FSM: WAIT (idle) -> LATCH when board_valid=1 and v_cnt>=480 -> WAIT after one cycle.
REQ-018 In LATCH, SHALL copy board_in into the shadow board and assert board_ack for that cycle only.
REQ-019 SHALL NOT latch while v_cnt<480; a request arriving mid-frame SHALL wait for blanking (no tearing).
REQ-020 SHALL require board_valid to deassert before another latch; board_valid held high after ack SHALL NOT cause a second ack until it has been seen low for at least one cycle.
REQ-021 SHALL update the shadow board only at a latch; curdata for all pixels of a given active frame SHALL come from a single board.
REQ-022 SHALL treat tile codes 12..15 as opaque data and pass them through unchanged.

Reset
REQ-023 On rst=1, SHALL immediately clear the shadow board to all 0, curpos/curdata/h_cnt_d/v_cnt_d to 0, board_ack to 0, FSM to WAIT, and the armed flag to armed, independent of clk.
REQ-024 A rst asserted during LATCH SHALL suppress the ack; the requester SHALL still see board_valid pending and be served at the next blanking after release.

Configuration
REQ-025 With macro NEW_TILE_BLINK_EN defined, the block SHALL add input new_pos (5 bits, 1..16, 0=none), sampled at latch.
REQ-026 With NEW_TILE_BLINK_EN defined, for 64 frames after a latch the tile at new_pos SHALL output curdata=0 during frames 0-15 and 32-47 and its true code during frames 16-31 and 48-63.
- Frames are counted at each h_cnt=0, v_cnt=480 event; the frame counter resets at every latch and saturates at 64.
REQ-027 Without NEW_TILE_BLINK_EN, SHALL have no new_pos port and no frame counter; curdata SHALL always equal the shadow cell.

Verification
REQ-028 Bench SHALL check geometry: board cell 5 = 4'h3, others 0; drive h=250, v=170 -> next cycle curpos=6, curdata=3; drive h=220, v=170 -> curpos=0, curdata=0.
REQ-029 Bench SHALL check corner pixels: h=136, v=66 -> curpos=1; h=503, v=433 -> curpos=16; h=504, v=433 -> curpos=0.
REQ-030 Bench SHALL check deferred latch: board_valid=1 at v=100 -> no board_ack until v reaches 480, then exactly one ack pulse; shadow unchanged before the ack.
REQ-031 Bench SHALL check the re-arm rule: board_valid held high through two blanking periods -> exactly one ack; drop board_valid for one cycle and reassert in blanking -> second ack.
REQ-032 Bench SHALL check reset: rst pulsed mid-frame with a loaded board -> curpos=0 and curdata=0 immediately; all cells read 0 afterwards.
REQ-033 Bench SHALL check blinking (NEW_TILE_BLINK_EN): latch with new_pos=16, cell 15=4'h1 -> curdata at h=430, v=360 is 0 in frame 3, 1 in frame 20, 0 in frame 40, and 1 from frame 64 onward.

Source files
------------

// File: rtl/board_scanner.sv
// Maps VGA pixel coordinates onto a 4x4 tile grid and serves tile codes from a shadow board.
// Optional feature macro: NEW_TILE_BLINK_EN (blinks the newly placed tile for 64 frames after a latch).
module board_scanner (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_cnt,
  input  logic [10:0] v_cnt,
  input  logic [63:0] board_in,
  input  logic        board_valid,
`ifdef NEW_TILE_BLINK_EN
  input  logic [4:0]  new_pos,
`endif
  output logic        board_ack,
  output logic [4:0]  curpos,
  output logic [3:0]  curdata,
  output logic [10:0] h_cnt_d,
  output logic [10:0] v_cnt_d
);

  typedef enum logic {S_WAIT, S_LATCH} state_t;

  state_t      r_state;
  logic        r_armed;
  logic        r_ack;
  logic [63:0] r_board;
  logic [4:0]  r_curpos;
  logic [3:0]  r_curdata;
  logic [10:0] r_h_d;
  logic [10:0] r_v_d;

  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic        w_col_ok;
  logic        w_row_ok;
  logic [4:0]  w_pos;
  logic [3:0]  w_cell;
  logic [3:0]  w_data;
  logic        w_blank;
  logic        w_do_latch;

`ifdef NEW_TILE_BLINK_EN
  logic [6:0]  r_frame;
  logic [4:0]  r_newpos;
  logic        w_frame_evt;
  logic        w_hide;
`endif

  always_comb begin
    w_col_ok = 1'b1;
    w_col    = '0;
    if      (h_cnt >= 11'd136 && h_cnt <= 11'd215) w_col = 2'd0;
    else if (h_cnt >= 11'd232 && h_cnt <= 11'd311) w_col = 2'd1;
    else if (h_cnt >= 11'd328 && h_cnt <= 11'd407) w_col = 2'd2;
    else if (h_cnt >= 11'd424 && h_cnt <= 11'd503) w_col = 2'd3;
    else                                           w_col_ok = 1'b0;

    w_row_ok = 1'b1;
    w_row    = '0;
    if      (v_cnt >= 11'd66  && v_cnt <= 11'd145) w_row = 2'd0;
    else if (v_cnt >= 11'd162 && v_cnt <= 11'd241) w_row = 2'd1;
    else if (v_cnt >= 11'd258 && v_cnt <= 11'd337) w_row = 2'd2;
    else if (v_cnt >= 11'd354 && v_cnt <= 11'd433) w_row = 2'd3;
    else                                           w_row_ok = 1'b0;
  end

  assign w_pos      = (w_col_ok && w_row_ok) ? ({1'b0, w_row, w_col} + 5'd1) : '0;
  assign w_cell     = r_board[{w_row, w_col, 2'b00} +: 4];
  assign w_blank    = (v_cnt >= 11'd480);
  assign w_do_latch = (r_state == S_WAIT) && board_valid && r_armed && w_blank;

`ifdef NEW_TILE_BLINK_EN
  assign w_frame_evt = (h_cnt == 11'd0) && (v_cnt == 11'd480);
  // Hidden during frames 0-15 and 32-47: bit 4 of the frame count is low there.
  assign w_hide      = (r_frame < 7'd64) && !r_frame[4] && (w_pos == r_newpos);
  assign w_data      = (w_pos == 5'd0 || w_hide) ? 4'd0 : w_cell;
`else
  assign w_data      = (w_pos == 5'd0) ? 4'd0 : w_cell;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_WAIT;
      r_armed   <= 1'b1;
      r_ack     <= 1'b0;
      r_board   <= '0;
      r_curpos  <= '0;
      r_curdata <= '0;
      r_h_d     <= '0;
      r_v_d     <= '0;
    end else begin
      r_curpos  <= w_pos;
      r_curdata <= w_data;
      r_h_d     <= h_cnt;
      r_v_d     <= v_cnt;
      if (!board_valid) r_armed <= 1'b1;
      // The shadow copy happens on the edge entering LATCH so the ack cycle already shows the new board.
      case (r_state)
        S_WAIT: begin
          r_ack <= 1'b0;
          if (w_do_latch) begin
            r_state <= S_LATCH;
            r_ack   <= 1'b1;
            r_board <= board_in;
            r_armed <= 1'b0;
          end
        end
        S_LATCH: begin
          r_ack   <= 1'b0;
          r_state <= S_WAIT;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= S_WAIT;
        end
      endcase
    end
  end

`ifdef NEW_TILE_BLINK_EN
  // Reset parks the counter saturated so nothing blinks until the first latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame  <= 7'd64;
      r_newpos <= '0;
    end else if (w_do_latch) begin
      r_frame  <= '0;
      r_newpos <= new_pos;
    end else if (w_frame_evt && r_frame != 7'd64) begin
      r_frame  <= r_frame + 7'd1;
    end
  end
`endif

  assign board_ack = r_ack;
  assign curpos    = r_curpos;
  assign curdata   = r_curdata;
  assign h_cnt_d   = r_h_d;
  assign v_cnt_d   = r_v_d;

endmodule

// File: tb/tb_board_scanner.sv
// Directed bench for board_scanner: geometry table, handshake sequences, reset and optional blink.
module tb_board_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] h_cnt = '0;
  logic [10:0] v_cnt = '0;
  logic [63:0] board_in = '0;
  logic        board_valid = 1'b0;
  logic        board_ack;
  logic [4:0]  curpos;
  logic [3:0]  curdata;
  logic [10:0] h_cnt_d;
  logic [10:0] v_cnt_d;
`ifdef NEW_TILE_BLINK_EN
  logic [4:0]  new_pos = '0;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] BOARD_A = 64'h0000_0000_0030_0000;
  localparam logic [63:0] BOARD_B = 64'hFEDC_BA98_7654_3210;

  board_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .board_in    (board_in),
    .board_valid (board_valid),
`ifdef NEW_TILE_BLINK_EN
    .new_pos     (new_pos),
`endif
    .board_ack   (board_ack),
    .curpos      (curpos),
    .curdata     (curdata),
    .h_cnt_d     (h_cnt_d),
    .v_cnt_d     (v_cnt_d)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [10:0] h;
    logic [10:0] v;
    logic [4:0]  pos;
    logic [3:0]  data;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [63:0] b);
    logic ok;
    ok = 1'b0;
    board_in    = b;
    board_valid = 1'b1;
    v_cnt       = 11'd500;
    h_cnt       = 11'd5;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (board_ack) ok = 1'b1;
    end
    chk("load_ack", {63'd0, ok}, 64'd1);
    board_valid = 1'b0;
    tick();
  endtask

  task automatic pix(input int h, input int v);
    h_cnt = 11'(h);
    v_cnt = 11'(v);
    tick();
  endtask

  initial begin
    int acks;
    logic cur_sel;

    vt[0]  = '{1'b0, 11'd250, 11'd170, 5'd6,  4'h3};
    vt[1]  = '{1'b0, 11'd220, 11'd170, 5'd0,  4'h0};
    vt[2]  = '{1'b0, 11'd136, 11'd66,  5'd1,  4'h0};
    vt[3]  = '{1'b0, 11'd503, 11'd433, 5'd16, 4'h0};
    vt[4]  = '{1'b0, 11'd504, 11'd433, 5'd0,  4'h0};
    vt[5]  = '{1'b1, 11'd136, 11'd66,  5'd1,  4'h0};
    vt[6]  = '{1'b1, 11'd215, 11'd145, 5'd1,  4'h0};
    vt[7]  = '{1'b1, 11'd216, 11'd66,  5'd0,  4'h0};
    vt[8]  = '{1'b1, 11'd232, 11'd66,  5'd2,  4'h1};
    vt[9]  = '{1'b1, 11'd503, 11'd433, 5'd16, 4'hF};
    vt[10] = '{1'b1, 11'd504, 11'd433, 5'd0,  4'h0};
    vt[11] = '{1'b1, 11'd424, 11'd354, 5'd16, 4'hF};
    vt[12] = '{1'b1, 11'd250, 11'd170, 5'd6,  4'h5};
    vt[13] = '{1'b1, 11'd328, 11'd258, 5'd11, 4'hA};
    vt[14] = '{1'b1, 11'd408, 11'd258, 5'd0,  4'h0};
    vt[15] = '{1'b1, 11'd135, 11'd66,  5'd0,  4'h0};
    vt[16] = '{1'b1, 11'd136, 11'd65,  5'd0,  4'h0};
    vt[17] = '{1'b1, 11'd136, 11'd434, 5'd0,  4'h0};
    vt[18] = '{1'b1, 11'd424, 11'd162, 5'd8,  4'h7};
    vt[19] = '{1'b1, 11'd136, 11'd354, 5'd13, 4'hC};
    vt[20] = '{1'b1, 11'd320, 11'd500, 5'd0,  4'h0};
    vt[21] = '{1'b1, 11'd700, 11'd100, 5'd0,  4'h0};
    vt[22] = '{1'b1, 11'd300, 11'd300, 5'd10, 4'h9};

    // Reset state
    h_cnt = 11'd250;
    v_cnt = 11'd170;
    tick();
    tick();
    chk("rst_curpos",  {59'd0, curpos},  64'd0);
    chk("rst_curdata", {60'd0, curdata}, 64'd0);
    chk("rst_ack",     {63'd0, board_ack}, 64'd0);
    chk("rst_hd",      {53'd0, h_cnt_d}, 64'd0);
    rst = 1'b0;

    // Geometry table
    cur_sel = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 0 || vt[i].sel != cur_sel) begin
        cur_sel = vt[i].sel;
        load(cur_sel ? BOARD_B : BOARD_A);
      end
      pix(int'(vt[i].h), int'(vt[i].v));
      chk($sformatf("vec%0d_pos", i),  {59'd0, curpos},  {59'd0, vt[i].pos});
      chk($sformatf("vec%0d_data", i), {60'd0, curdata}, {60'd0, vt[i].data});
      chk($sformatf("vec%0d_hd", i),   {53'd0, h_cnt_d}, {53'd0, vt[i].h});
      chk($sformatf("vec%0d_vd", i),   {53'd0, v_cnt_d}, {53'd0, vt[i].v});
    end

    // Deferred latch: request mid-frame, shadow (board B) must stay until blanking
    board_in    = BOARD_A;
    board_valid = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      pix(250, 100 + 14 * i);
      if (board_ack) acks++;
    end
    pix(250, 170);
    if (board_ack) acks++;
    chk("defer_hold_data", {60'd0, curdata}, 64'h5);
    pix(250, 479);
    if (board_ack) acks++;
    chk("defer_no_ack", 64'(acks), 64'd0);
    for (int i = 0; i < 20; i++) begin
      pix(100, 480);
      if (board_ack) acks++;
    end
    chk("defer_one_ack", 64'(acks), 64'd1);
    pix(250, 170);
    chk("defer_new_data", {60'd0, curdata}, 64'h3);

    // Re-arm: valid held across two blanking periods gives no further ack
    acks = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        pix(250, 100);
        if (board_ack) acks++;
      end
      for (int i = 0; i < 10; i++) begin
        pix(10, 490);
        if (board_ack) acks++;
      end
    end
    chk("rearm_held", 64'(acks), 64'd0);
    board_valid = 1'b0;
    pix(10, 490);
    board_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix(10, 490);
      if (board_ack) acks++;
    end
    chk("rearm_second", 64'(acks), 64'd1);
    board_valid = 1'b0;
    pix(10, 490);

    // Reset mid-frame with board A loaded
    pix(250, 170);
    chk("prerst_data", {60'd0, curdata}, 64'h3);
    #2 rst = 1'b1;
    #1;
    chk("async_curpos",  {59'd0, curpos},  64'd0);
    chk("async_curdata", {60'd0, curdata}, 64'd0);
    #1 rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pix(136 + 96 * c, 66 + 96 * r);
        chk($sformatf("clr_pos%0d", r * 4 + c), {59'd0, curpos}, 64'(r * 4 + c + 1));
        chk($sformatf("clr_data%0d", r * 4 + c), {60'd0, curdata}, 64'd0);
      end
    end

    // Reset during LATCH suppresses ack; pending request served afterwards
    board_in    = BOARD_A;
    board_valid = 1'b1;
    pix(10, 490);
    chk("latch_ack", {63'd0, board_ack}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("latch_rst_ack", {63'd0, board_ack}, 64'd0);
    rst = 1'b0;
    pix(10, 490);
    chk("latch_reserve", {63'd0, board_ack}, 64'd1);
    board_valid = 1'b0;
    pix(10, 490);
    pix(250, 170);
    chk("latch_reserve_data", {60'd0, curdata}, 64'h3);

`ifdef NEW_TILE_BLINK_EN
    begin
      int frame;
      logic [3:0] exp_d [5];
      int chk_f [5];
      chk_f = '{3, 20, 40, 64, 70};
      exp_d = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h1};
      new_pos = 5'd16;
      load(64'h1000_0000_0000_0000);
      frame = 0;
      for (int k = 0; k < 5; k++) begin
        while (frame < chk_f[k]) begin
          pix(0, 480);
          pix(5, 481);
          frame++;
        end
        pix(430, 360);
        chk($sformatf("blink_f%0d", chk_f[k]), {60'd0, curdata}, {60'd0, exp_d[k]});
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
